// File: rtl/instr_mem_if.sv
// Instruction fetch bus plus preload port shared by the memory responder and its requester.
//
// Signals:
//   instr_req_ip    requester -> responder  fetch request; instr_addr_ip valid while high
//   instr_addr_ip   requester -> responder  byte address of the requested instruction
//   instr_gnt_op    responder -> requester  request accepted this cycle
//   instr_rvalid_op responder -> requester  one-cycle response pulse
//   instr_rdata_op  responder -> requester  returned instruction word (0 outside rvalid)
//   instr_err_op    responder -> requester  response is an error (0 outside rvalid)
//   load_we_ip      loader -> responder     preload write strobe
//   load_addr_ip    loader -> responder     preload byte address, word-aligned
//   load_data_ip    loader -> responder     preload data word
//
// Modports: master drives requests and preloads; slave is the responder.
interface instr_mem_if;
  logic        instr_req_ip;
  logic [31:0] instr_addr_ip;
  logic        instr_gnt_op;
  logic        instr_rvalid_op;
  logic [31:0] instr_rdata_op;
  logic        instr_err_op;
  logic        load_we_ip;
  logic [31:0] load_addr_ip;
  logic [31:0] load_data_ip;

  modport master (
    output instr_req_ip, instr_addr_ip, load_we_ip, load_addr_ip, load_data_ip,
    input  instr_gnt_op, instr_rvalid_op, instr_rdata_op, instr_err_op
  );

  modport slave (
    input  instr_req_ip, instr_addr_ip, load_we_ip, load_addr_ip, load_data_ip,
    output instr_gnt_op, instr_rvalid_op, instr_rdata_op, instr_err_op
  );
endinterface

// File: rtl/instr_mem_responder.sv
// Instruction memory responder: a word-addressed memory behind a req/gnt/rvalid fetch
// bus with a fixed, parameterised response latency and at most one request in flight.
// Misaligned or out-of-range fetches are granted and answered with an error response.
// The memory is filled through a separate preload port that works in any state,
// including while reset is held.
//
// Parameters:
//   DEPTH    memory size in 32-bit words (power of two, 4..1024)
//   LATENCY  cycles from the grant edge to the response (1..15)
//
// Ports:
//   clock    single clock, rising-edge active
//   reset    asynchronous, active-low reset (memory contents are preserved)
//   bus      instr_mem_if slave modport (fetch handshake + preload port)
module instr_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  instr_mem_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        gnt;
  logic [31:0] addr_p1;
  logic [31:0] rdata_p1;
  logic        vld_p1;
  logic        err_p1;
  logic [31:0] mem [DEPTH];

  // Word-aligned and below 4*DEPTH bytes.
  function automatic logic addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a[31:AW+2] == '0);
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return a[AW+1:2];
  endfunction

  // Grant is masked by reset so nothing is accepted while reset is held low.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = bus.instr_req_ip && reset && (state_q == IDLE || state_q == RESP);
    case (state_q)
      IDLE, RESP: begin
        if (gnt) begin
          cnt_d   = 4'(LATENCY - 1);
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end else if (state_q == RESP) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        // Leaving WAIT as the counter hits zero puts RESP exactly LATENCY cycles after grant.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p1: control state and captured request address.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_p1 <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (gnt) addr_p1 <= bus.instr_addr_ip;
    end
  end

  // Stage p1: memory read at the grant edge; a same-edge preload lands after the read.
  always_ff @(posedge clock) begin
    if (gnt) rdata_p1 <= mem[word_idx(bus.instr_addr_ip)];
    if (bus.load_we_ip && addr_ok(bus.load_addr_ip))
      mem[word_idx(bus.load_addr_ip)] <= bus.load_data_ip;
  end

  // Response outputs are forced to zero outside the RESP pulse.
  assign vld_p1              = (state_q == RESP);
  assign err_p1              = vld_p1 && !addr_ok(addr_p1);
  assign bus.instr_gnt_op    = gnt;
  assign bus.instr_rvalid_op = vld_p1;
  assign bus.instr_err_op    = err_p1;
  assign bus.instr_rdata_op  = (vld_p1 && !err_p1) ? rdata_p1 : '0;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder: three instances (LATENCY 1, 3 and 4) share
// clock and reset. Inputs change just after each falling edge; outputs are sampled 1ns
// later, so "cycle k" is the clock period whose rising edge ends it.
module tb_instr_mem_responder;

  logic clock;
  logic reset;
  int   n_vec;
  int   n_err;

  instr_mem_if if1 ();
  instr_mem_if if3 ();
  instr_mem_if if4 ();

  instr_mem_responder #(.DEPTH(256), .LATENCY(1)) u_lat1 (.clock(clock), .reset(reset), .bus(if1.slave));
  instr_mem_responder #(.DEPTH(256), .LATENCY(3)) u_lat3 (.clock(clock), .reset(reset), .bus(if3.slave));
  instr_mem_responder #(.DEPTH(256), .LATENCY(4)) u_lat4 (.clock(clock), .reset(reset), .bus(if4.slave));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic load_all(input logic [31:0] a, input logic [31:0] d);
    tick();
    if1.load_we_ip = 1'b1; if1.load_addr_ip = a; if1.load_data_ip = d;
    if3.load_we_ip = 1'b1; if3.load_addr_ip = a; if3.load_data_ip = d;
    if4.load_we_ip = 1'b1; if4.load_addr_ip = a; if4.load_data_ip = d;
    tick();
    if1.load_we_ip = 1'b0;
    if3.load_we_ip = 1'b0;
    if4.load_we_ip = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    if1.instr_req_ip = 1'b0; if1.instr_addr_ip = '0; if1.load_we_ip = 1'b0; if1.load_addr_ip = '0; if1.load_data_ip = '0;
    if3.instr_req_ip = 1'b0; if3.instr_addr_ip = '0; if3.load_we_ip = 1'b0; if3.load_addr_ip = '0; if3.load_data_ip = '0;
    if4.instr_req_ip = 1'b0; if4.instr_addr_ip = '0; if4.load_we_ip = 1'b0; if4.load_addr_ip = '0; if4.load_data_ip = '0;
    reset = 1'b1;
    #2 reset = 1'b0;

    // Reset state, and no grant while reset is low.
    #1;
    chk1("rst_rvalid", if1.instr_rvalid_op, 1'b0);
    chk1("rst_err", if1.instr_err_op, 1'b0);
    chk32("rst_rdata", if1.instr_rdata_op, 32'h0);
    if1.instr_req_ip = 1'b1;
    #1 chk1("rst_gnt", if1.instr_gnt_op, 1'b0);
    if1.instr_req_ip = 1'b0;

    // Preload while reset is held.
    load_all(32'h0000_0000, 32'h0000_0013);
    load_all(32'h0000_0004, 32'h0010_0093);
    load_all(32'h0000_0008, 32'hDEAD_BEEF);
    load_all(32'h0000_0014, 32'h2222_2222);
    load_all(32'h0000_03FC, 32'hCAFE_F00D);
    tick();
    reset = 1'b1;

    // LATENCY=1 back-to-back fetches of addr 0 then 4.
    tick(); if1.instr_req_ip = 1'b1; if1.instr_addr_ip = 32'h0;
    #1 chk1("l1_c0_gnt", if1.instr_gnt_op, 1'b1); chk1("l1_c0_rvalid", if1.instr_rvalid_op, 1'b0);
    tick(); if1.instr_addr_ip = 32'h4;
    #1 chk1("l1_c1_gnt", if1.instr_gnt_op, 1'b1); chk1("l1_c1_rvalid", if1.instr_rvalid_op, 1'b1);
    chk32("l1_c1_rdata", if1.instr_rdata_op, 32'h0000_0013); chk1("l1_c1_err", if1.instr_err_op, 1'b0);
    tick(); if1.instr_req_ip = 1'b0;
    #1 chk1("l1_c2_gnt", if1.instr_gnt_op, 1'b0); chk1("l1_c2_rvalid", if1.instr_rvalid_op, 1'b1);
    chk32("l1_c2_rdata", if1.instr_rdata_op, 32'h0010_0093);
    tick();
    #1 chk1("l1_c3_rvalid", if1.instr_rvalid_op, 1'b0); chk32("l1_c3_rdata", if1.instr_rdata_op, 32'h0);

    // LATENCY=3 single fetch of addr 0x8 with request held through WAIT.
    tick(); if3.instr_req_ip = 1'b1; if3.instr_addr_ip = 32'h8;
    #1 chk1("l3_c0_gnt", if3.instr_gnt_op, 1'b1);
    tick();
    #1 chk1("l3_c1_gnt", if3.instr_gnt_op, 1'b0); chk1("l3_c1_rvalid", if3.instr_rvalid_op, 1'b0);
    tick();
    #1 chk1("l3_c2_gnt", if3.instr_gnt_op, 1'b0); chk1("l3_c2_rvalid", if3.instr_rvalid_op, 1'b0);
    tick(); if3.instr_req_ip = 1'b0;
    #1 chk1("l3_c3_rvalid", if3.instr_rvalid_op, 1'b1); chk32("l3_c3_rdata", if3.instr_rdata_op, 32'hDEAD_BEEF);
    chk1("l3_c3_err", if3.instr_err_op, 1'b0); chk1("l3_c3_gnt", if3.instr_gnt_op, 1'b0);

    // LATENCY=3 throughput: new grant in RESP, one response per 3 cycles.
    tick(); if3.instr_req_ip = 1'b1; if3.instr_addr_ip = 32'h0;
    #1 chk1("tp_c0_gnt", if3.instr_gnt_op, 1'b1); chk1("tp_c0_rvalid", if3.instr_rvalid_op, 1'b0);
    tick();
    #1 chk1("tp_c1_gnt", if3.instr_gnt_op, 1'b0);
    tick();
    #1 chk1("tp_c2_gnt", if3.instr_gnt_op, 1'b0);
    tick(); if3.instr_addr_ip = 32'h4;
    #1 chk1("tp_c3_gnt", if3.instr_gnt_op, 1'b1); chk1("tp_c3_rvalid", if3.instr_rvalid_op, 1'b1);
    chk32("tp_c3_rdata", if3.instr_rdata_op, 32'h0000_0013);
    tick(); if3.instr_req_ip = 1'b0;
    #1 chk1("tp_c4_rvalid", if3.instr_rvalid_op, 1'b0);
    tick();
    #1 chk1("tp_c5_rvalid", if3.instr_rvalid_op, 1'b0);
    tick();
    #1 chk1("tp_c6_rvalid", if3.instr_rvalid_op, 1'b1); chk32("tp_c6_rdata", if3.instr_rdata_op, 32'h0010_0093);
    tick();
    #1 chk1("tp_c7_rvalid", if3.instr_rvalid_op, 1'b0);

    // Error responses: misaligned, out of range; last in-range word is fine.
    tick(); if1.instr_req_ip = 1'b1; if1.instr_addr_ip = 32'h6;
    #1 chk1("mis_gnt", if1.instr_gnt_op, 1'b1);
    tick(); if1.instr_req_ip = 1'b0;
    #1 chk1("mis_rvalid", if1.instr_rvalid_op, 1'b1); chk1("mis_err", if1.instr_err_op, 1'b1);
    chk32("mis_rdata", if1.instr_rdata_op, 32'h0);
    tick(); if1.instr_req_ip = 1'b1; if1.instr_addr_ip = 32'h400;
    #1 chk1("oor_gnt", if1.instr_gnt_op, 1'b1);
    tick(); if1.instr_req_ip = 1'b0;
    #1 chk1("oor_rvalid", if1.instr_rvalid_op, 1'b1); chk1("oor_err", if1.instr_err_op, 1'b1);
    chk32("oor_rdata", if1.instr_rdata_op, 32'h0);
    tick(); if1.instr_req_ip = 1'b1; if1.instr_addr_ip = 32'h3FC;
    tick(); if1.instr_req_ip = 1'b0;
    #1 chk1("top_err", if1.instr_err_op, 1'b0); chk32("top_rdata", if1.instr_rdata_op, 32'hCAFE_F00D);

    // Misaligned and out-of-range preloads must be dropped.
    load_all(32'h0000_0016, 32'hBADB_AD00);
    load_all(32'h0000_0400, 32'h0BAD_0BAD);

    // Preload colliding with a grant to the same word.
    tick(); if1.instr_req_ip = 1'b1; if1.instr_addr_ip = 32'h14;
    if1.load_we_ip = 1'b1; if1.load_addr_ip = 32'h14; if1.load_data_ip = 32'h1111_1111;
    #1 chk1("col_gnt", if1.instr_gnt_op, 1'b1);
    tick(); if1.instr_req_ip = 1'b0; if1.load_we_ip = 1'b0;
    #1 chk1("col_rvalid", if1.instr_rvalid_op, 1'b1); chk32("col_rdata", if1.instr_rdata_op, 32'h2222_2222);
    tick(); if1.instr_req_ip = 1'b1; if1.instr_addr_ip = 32'h14;
    tick(); if1.instr_req_ip = 1'b0;
    #1 chk32("col_reread", if1.instr_rdata_op, 32'h1111_1111);
    tick(); if1.instr_req_ip = 1'b1; if1.instr_addr_ip = 32'h0;
    tick(); if1.instr_req_ip = 1'b0;
    #1 chk32("oor_load_ignored", if1.instr_rdata_op, 32'h0000_0013);

    // Reset mid-transaction: LATENCY=4 in WAIT, LATENCY=1 in RESP.
    tick(); if4.instr_req_ip = 1'b1; if4.instr_addr_ip = 32'h8;
    #1 chk1("rw_l4_gnt", if4.instr_gnt_op, 1'b1);
    tick(); if4.instr_req_ip = 1'b0; if1.instr_req_ip = 1'b1; if1.instr_addr_ip = 32'h0;
    #1 chk1("rw_l1_gnt", if1.instr_gnt_op, 1'b1);
    tick(); if1.instr_req_ip = 1'b0;
    #1 chk1("rw_l1_pre_rvalid", if1.instr_rvalid_op, 1'b1);
    reset = 1'b0;
    #1 chk1("rw_l1_rvalid", if1.instr_rvalid_op, 1'b0); chk32("rw_l1_rdata", if1.instr_rdata_op, 32'h0);
    chk1("rw_l4_rvalid", if4.instr_rvalid_op, 1'b0);
    if3.instr_req_ip = 1'b1;
    #1 chk1("rw_l3_gnt", if3.instr_gnt_op, 1'b0);
    if3.instr_req_ip = 1'b0;
    tick(); reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      #1 chk1("rw_l4_quiet", if4.instr_rvalid_op, 1'b0); chk1("rw_l1_quiet", if1.instr_rvalid_op, 1'b0);
    end
    tick(); if4.instr_req_ip = 1'b1; if4.instr_addr_ip = 32'h8;
    #1 chk1("rw_new_gnt", if4.instr_gnt_op, 1'b1);
    tick(); if4.instr_req_ip = 1'b0;
    #1 chk1("rw_new_c1", if4.instr_rvalid_op, 1'b0);
    tick();
    #1 chk1("rw_new_c2", if4.instr_rvalid_op, 1'b0);
    tick();
    #1 chk1("rw_new_c3", if4.instr_rvalid_op, 1'b0);
    tick();
    #1 chk1("rw_new_c4", if4.instr_rvalid_op, 1'b1); chk32("rw_new_rdata", if4.instr_rdata_op, 32'hDEAD_BEEF);
    tick();
    #1 chk1("rw_new_c5", if4.instr_rvalid_op, 1'b0);

    // Idle with req low: every output stays low.
    for (int i = 0; i < 10; i++) begin
      tick();
      #1 chk32("idle_ctrl", {29'b0, if1.instr_gnt_op, if1.instr_rvalid_op, if1.instr_err_op}, 32'h0);
      chk32("idle_rdata", if1.instr_rdata_op, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
